axis_frame_filter_fifo: RTL

- Store-and-forward frame FIFO that sits directly downstream of the AXI4-Stream tap's m_axis output.
- Commits only complete, good frames.
- Discards frames whose last word carries the bad-frame tuser marker, which includes the tap's truncation marker.
- Discards frames that overflow the buffer.
- The input never backpressures, so a monitor path never stalls the mirrored link.

---
 rtl/axis_frame_filter_pkg.sv | 23 ++
 rtl/axis_frame_filter_fifo_if.sv | 16 +
 rtl/axis_frame_filter_ram.sv | 23 ++
 rtl/axis_frame_filter_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/axis_frame_filter_pkg.sv
// Shared types, constants and the bad-frame compare for the AXI4-Stream frame filter FIFO.
package axis_frame_filter_pkg;

  // state     | meaning
  // ST_ACCEPT | storing words of the current frame into the RAM
  // ST_DROP   | frame overflowed; discard words until its tlast
  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } state_t;

  localparam int STAT_WIDTH     = 32;
  localparam int USER_MAX_WIDTH = 32;

  function automatic logic is_bad_frame(
    input logic [USER_MAX_WIDTH-1:0] user,
    input logic [USER_MAX_WIDTH-1:0] value,
    input logic [USER_MAX_WIDTH-1:0] mask
  );
    return ((user ^ value) & mask) == '0;
  endfunction

endpackage

// File: rtl/axis_frame_filter_fifo_if.sv
// AXI4-Stream bundle used for both sides of the frame filter FIFO.
interface axis_frame_filter_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_filter_ram.sv
// Simple dual-port RAM with a registered read port for the frame filter FIFO.
module axis_frame_filter_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int WIDTH      = 10
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);
  logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/axis_frame_filter_fifo.sv
// Store-and-forward frame FIFO: commits good frames, drops bad-marked and overflowing ones.
// Define AXIS_FRAME_FILTER_STATS_EN to add saturating good/bad/overflow frame counters.
module axis_frame_filter_fifo
  import axis_frame_filter_pkg::*;
#(
  parameter int                    DEPTH                = 4096,
  parameter int                    DATA_WIDTH           = 8,
  parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH           = (DATA_WIDTH + 7) / 8,
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  axis_frame_filter_fifo_if.slave  s_axis,
  axis_frame_filter_fifo_if.master m_axis,
  output logic                     status_good_frame,
  output logic                     status_bad_frame,
  output logic                     status_overflow
`ifdef AXIS_FRAME_FILTER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]    stat_good_count,
  output logic [STAT_WIDTH-1:0]    stat_bad_count,
  output logic [STAT_WIDTH-1:0]    stat_overflow_count
`endif
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int RAM_WIDTH  = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH:0]   r_wr_ptr_cur, r_wr_ptr_commit, r_rd_ptr;
  logic [ADDR_WIDTH:0]   w_wr_ptr_cur_next, w_wr_ptr_commit_next;
  logic                  r_s_tready, w_accept, w_full, w_bad, w_wr_en;
  logic                  w_good_p, w_bad_p, w_ovf_p;
  logic                  r_status_good, r_status_bad, r_status_ovf;
  logic                  w_rd_en, w_store_out, r_mid_valid, r_out_valid;
  logic [RAM_WIDTH-1:0]  w_wr_data, w_rd_data, r_out_data;

  assign w_accept  = s_axis.tvalid && r_s_tready;
  assign w_full    = (r_wr_ptr_cur == {~r_rd_ptr[ADDR_WIDTH], r_rd_ptr[ADDR_WIDTH-1:0]});
  assign w_bad     = is_bad_frame(USER_MAX_WIDTH'(s_axis.tuser),
                                  USER_MAX_WIDTH'(USER_BAD_FRAME_VALUE),
                                  USER_MAX_WIDTH'(USER_BAD_FRAME_MASK));
  assign w_wr_data = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_ACCEPT;
      r_wr_ptr_cur    <= '0;
      r_wr_ptr_commit <= '0;
      r_s_tready      <= 1'b0;
      r_status_good   <= 1'b0;
      r_status_bad    <= 1'b0;
      r_status_ovf    <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_wr_ptr_cur    <= w_wr_ptr_cur_next;
      r_wr_ptr_commit <= w_wr_ptr_commit_next;
      r_s_tready      <= 1'b1;
      r_status_good   <= w_good_p;
      r_status_bad    <= w_bad_p;
      r_status_ovf    <= w_ovf_p;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_wr_en              = 1'b0;
    w_wr_ptr_cur_next    = r_wr_ptr_cur;
    w_wr_ptr_commit_next = r_wr_ptr_commit;
    w_good_p             = 1'b0;
    w_bad_p              = 1'b0;
    w_ovf_p              = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_ACCEPT: begin
          if (w_full) begin
            w_wr_ptr_cur_next = r_wr_ptr_commit;
            if (s_axis.tlast) w_ovf_p = 1'b1;
            else              w_state_next = ST_DROP;
          end else begin
            w_wr_en           = 1'b1;
            w_wr_ptr_cur_next = r_wr_ptr_cur + PTR_ONE;
            if (s_axis.tlast) begin
              if (w_bad) begin
                w_wr_ptr_cur_next = r_wr_ptr_commit;
                w_bad_p           = 1'b1;
              end else begin
                w_wr_ptr_commit_next = r_wr_ptr_cur + PTR_ONE;
                w_good_p             = 1'b1;
              end
            end
          end
        end
        ST_DROP: begin
          if (s_axis.tlast) begin
            w_ovf_p      = 1'b1;
            w_state_next = ST_ACCEPT;
          end
        end
        default: w_state_next = ST_ACCEPT;
      endcase
    end
  end

  // RAM read stage refills whenever the output register drains, giving 1 word/cycle.
  assign w_store_out = r_mid_valid && (!r_out_valid || m_axis.tready);
  assign w_rd_en     = (r_rd_ptr != r_wr_ptr_commit) && (!r_mid_valid || w_store_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_mid_valid <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_rd_en) begin
        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
        r_mid_valid <= 1'b1;
      end else if (w_store_out) begin
        r_mid_valid <= 1'b0;
      end
      if (w_store_out)        r_out_valid <= 1'b1;
      else if (m_axis.tready) r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_store_out) r_out_data <= w_rd_data;
  end

  axis_frame_filter_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WIDTH     (RAM_WIDTH)
  ) u_ram (
    .clk      (clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wr_ptr_cur[ADDR_WIDTH-1:0]),
    .i_wr_data(w_wr_data),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rd_data(w_rd_data)
  );

  assign s_axis.tready     = r_s_tready;
  assign m_axis.tvalid     = r_out_valid;
  assign m_axis.tdata      = r_out_data[DATA_WIDTH-1:0];
  assign m_axis.tkeep      = KEEP_ENABLE ? r_out_data[DATA_WIDTH +: KEEP_WIDTH] : '1;
  assign m_axis.tlast      = r_out_data[RAM_WIDTH-1];
  assign m_axis.tuser      = '0;
  assign status_good_frame = r_status_good;
  assign status_bad_frame  = r_status_bad;
  assign status_overflow   = r_status_ovf;

`ifdef AXIS_FRAME_FILTER_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};
  logic [STAT_WIDTH-1:0] r_good_cnt, r_bad_cnt, r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      if (r_status_good && (r_good_cnt != '1)) r_good_cnt <= r_good_cnt + STAT_ONE;
      if (r_status_bad  && (r_bad_cnt  != '1)) r_bad_cnt  <= r_bad_cnt  + STAT_ONE;
      if (r_status_ovf  && (r_ovf_cnt  != '1)) r_ovf_cnt  <= r_ovf_cnt  + STAT_ONE;
    end
  end

  assign stat_good_count     = r_good_cnt;
  assign stat_bad_count      = r_bad_cnt;
  assign stat_overflow_count = r_ovf_cnt;
`endif
endmodule
